// File: rtl/bamse_pkg.sv
// rtl/bamse_pkg.sv - shared widths, opcodes and condition codes for the bamse microcontroller
package bamse_pkg;

    localparam int CODE_W = 18;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int REG_N  = 16;

    localparam logic [ADDR_W-1:0] INT_VECTOR = 10'h3FF;

    // Even opcode of each pair; the odd partner selects the sY operand form
    localparam logic [5:0] OP_LOAD    = 6'h00;
    localparam logic [5:0] OP_INPUT   = 6'h04;
    localparam logic [5:0] OP_AND     = 6'h0A;
    localparam logic [5:0] OP_OR      = 6'h0C;
    localparam logic [5:0] OP_XOR     = 6'h0E;
    localparam logic [5:0] OP_COMPARE = 6'h14;
    localparam logic [5:0] OP_ADD     = 6'h18;
    localparam logic [5:0] OP_ADDCY   = 6'h1A;
    localparam logic [5:0] OP_SUB     = 6'h1C;
    localparam logic [5:0] OP_SUBCY   = 6'h1E;
    localparam logic [5:0] OP_RETURN  = 6'h2A;
    localparam logic [5:0] OP_OUTPUT  = 6'h2C;
    localparam logic [5:0] OP_CALL    = 6'h30;
    localparam logic [5:0] OP_JUMP    = 6'h34;
    localparam logic [5:0] OP_RETURNI = 6'h38;
    localparam logic [5:0] OP_INTEN   = 6'h3C;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    function automatic logic cond_met(input logic [1:0] cc, input logic z, input logic c);
        case (cc)
            COND_Z:  return z;
            COND_NZ: return !z;
            COND_C:  return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/bamse_core.sv
// rtl/bamse_core.sv - two-clock KCPSM3-encoded core: decode, ALU, flags, stack, interrupts
module bamse_core
    import bamse_pkg::*;
#(
    parameter int STACK_DEPTH = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [CODE_W-1:0] instruction,
    input  logic [DATA_W-1:0] in_port,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

    logic              timing_control;
    logic [ADDR_W-1:0] pc;
    logic              z_flag, c_flag, shadow_z, shadow_c;
    logic              ie, pending, irq_q;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack [0:STACK_DEPTH-1];

    logic [5:0]        opcode, op_group;
    logic [3:0]        sx_addr, sy_addr;
    logic [DATA_W-1:0] kk, sx_val, sy_val, operand;
    logic [ADDR_W-1:0] aaa, pc_inc;
    logic              cond_ok, service, cin;
    logic [SP_W-1:0]   sp_inc, sp_dec;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   wide;
    logic              alu_c, alu_z, alu_flags, alu_write;

    logic [ADDR_W-1:0] pc_next, push_val;
    logic              z_next, c_next, ie_next, push, reg_we;
    logic [SP_W-1:0]   sp_next;

    assign opcode   = instruction[17:12];
    assign op_group = {opcode[5:1], 1'b0};
    assign sx_addr  = instruction[11:8];
    assign sy_addr  = instruction[7:4];
    assign kk       = instruction[7:0];
    assign aaa      = instruction[9:0];
    assign operand  = opcode[0] ? sy_val : kk;
    assign cin      = opcode[1] & c_flag;
    assign cond_ok  = !opcode[0] || cond_met(instruction[11:10], z_flag, c_flag);
    assign pc_inc   = pc + 1'b1;
    assign sp_inc   = (sp == SP_LAST) ? '0 : sp + 1'b1;
    assign sp_dec   = (sp == '0) ? SP_LAST : sp - 1'b1;
    assign service  = timing_control && pending;
    assign alu_z    = (alu_res == '0);

    assign address  = pc;
    assign port_id  = operand;
    assign out_port = sx_val;

    bamse_regfile register (
        .clk    (clk),
        .we     (reg_we),
        .waddr  (sx_addr),
        .wdata  (alu_res),
        .addr_x (sx_addr),
        .addr_y (sy_addr),
        .data_x (sx_val),
        .data_y (sy_val)
    );

    // ALU: result, carry/borrow, and whether flags and sX get updated
    always_comb begin
        alu_res   = operand;
        alu_c     = c_flag;
        alu_flags = 1'b0;
        alu_write = 1'b0;
        wide      = '0;
        case (op_group)
            OP_LOAD: alu_write = 1'b1;
            OP_INPUT: begin
                alu_res   = in_port;
                alu_write = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (op_group == OP_AND)     alu_res = sx_val & operand;
                else if (op_group == OP_OR) alu_res = sx_val | operand;
                else                        alu_res = sx_val ^ operand;
                alu_c     = 1'b0;
                alu_flags = 1'b1;
                alu_write = 1'b1;
            end
            OP_ADD, OP_ADDCY: begin
                wide      = {1'b0, sx_val} + {1'b0, operand} + {{DATA_W{1'b0}}, cin};
                alu_res   = wide[DATA_W-1:0];
                alu_c     = wide[DATA_W];
                alu_flags = 1'b1;
                alu_write = 1'b1;
            end
            OP_COMPARE, OP_SUB, OP_SUBCY: begin
                wide      = {1'b0, sx_val} - {1'b0, operand} - {{DATA_W{1'b0}}, cin};
                alu_res   = wide[DATA_W-1:0];
                alu_c     = wide[DATA_W];
                alu_flags = 1'b1;
                alu_write = (op_group != OP_COMPARE);
            end
            default: ;
        endcase
    end

    // Next-state for PC, flags, IE and stack; an interrupt replaces the instruction
    always_comb begin
        pc_next      = pc;
        z_next       = z_flag;
        c_next       = c_flag;
        ie_next      = ie;
        sp_next      = sp;
        push         = 1'b0;
        push_val     = pc_inc;
        reg_we       = 1'b0;
        write_strobe = 1'b0;
        if (service) begin
            push     = 1'b1;
            push_val = pc;
            sp_next  = sp_inc;
            ie_next  = 1'b0;
            pc_next  = INT_VECTOR;
        end else if (timing_control) begin
            pc_next = pc_inc;
            reg_we  = alu_write;
            if (alu_flags) begin
                z_next = alu_z;
                c_next = alu_c;
            end
            case (op_group)
                OP_OUTPUT: write_strobe = 1'b1;
                OP_JUMP: begin
                    if (cond_ok) pc_next = aaa;
                end
                OP_CALL: begin
                    if (cond_ok) begin
                        push    = 1'b1;
                        sp_next = sp_inc;
                        pc_next = aaa;
                    end
                end
                OP_RETURN: begin
                    if (cond_ok) begin
                        pc_next = stack[sp_dec];
                        sp_next = sp_dec;
                    end
                end
                OP_RETURNI: begin
                    if (!opcode[0]) begin
                        pc_next = stack[sp_dec];
                        sp_next = sp_dec;
                        z_next  = shadow_z;
                        c_next  = shadow_c;
                        ie_next = instruction[0];
                    end
                end
                OP_INTEN: begin
                    if (!opcode[0]) ie_next = instruction[0];
                end
                default: ;
            endcase
        end
    end

    // Architectural state; pending latches an irq rising edge only while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            timing_control <= 1'b0;
            pc             <= '0;
            z_flag         <= 1'b0;
            c_flag         <= 1'b0;
            shadow_z       <= 1'b0;
            shadow_c       <= 1'b0;
            ie             <= 1'b0;
            pending        <= 1'b0;
            irq_q          <= 1'b0;
            sp             <= '0;
        end else begin
            timing_control <= !timing_control;
            irq_q          <= irq;
            pc             <= pc_next;
            z_flag         <= z_next;
            c_flag         <= c_next;
            ie             <= ie_next;
            sp             <= sp_next;
            if (service) begin
                shadow_z <= z_flag;
                shadow_c <= c_flag;
                pending  <= 1'b0;
            end else if (irq && !irq_q && ie) begin
                pending <= 1'b1;
            end
        end
    end

    // Circular return stack; overflow overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack[sp] <= push_val;
        end
    end

endmodule

// File: rtl/bamse_regfile.sv
// rtl/bamse_regfile.sv - 16x8 register file, one write port, two async read ports
module bamse_regfile
    import bamse_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        addr_x,
    input  logic [3:0]        addr_y,
    output logic [DATA_W-1:0] data_x,
    output logic [DATA_W-1:0] data_y
);

    logic [DATA_W-1:0] dpr [0:REG_N-1];

    // Register contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            dpr[waddr] <= wdata;
        end
    end

    assign data_x = dpr[addr_x];
    assign data_y = dpr[addr_y];

endmodule

// File: rtl/bamse_rom.sv
// rtl/bamse_rom.sv - synchronous-read program memory
module bamse_rom
    import bamse_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CODE_W-1:0] load_data,
    input  logic [ADDR_W-1:0] addr,
    output logic [CODE_W-1:0] data
);

    logic [CODE_W-1:0] ram [0:DEPTH-1];

    // Read every clock; the address only moves on phase-1 edges, so the word
    // captured during phase 0 is the one executed in phase 1
    always_ff @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end
        data <= ram[addr];
    end

endmodule

// File: rtl/bamse_top.sv
// rtl/bamse_top.sv - bamse microcontroller top: core, program ROM and output port A
module bamse_top
    import bamse_pkg::*;
#(
    parameter int          ROM_DEPTH   = 1024,
    parameter logic [7:0]  PORTA_ID    = 8'h00,
    parameter int          STACK_DEPTH = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    output logic [7:0]  portA_out,
    input  logic [7:0]  portB_in
);

    logic [ADDR_W-1:0] addr;
    logic [CODE_W-1:0] din;
    logic [DATA_W-1:0] port_id, out_port;
    logic              write_strobe;

    bamse_rom #(.DEPTH(ROM_DEPTH)) rom (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ({ADDR_W{1'b0}}),
        .load_data ({CODE_W{1'b0}}),
        .addr      (addr),
        .data      (din)
    );

    bamse_core #(.STACK_DEPTH(STACK_DEPTH)) pblaze (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .instruction  (din),
        .in_port      (portB_in),
        .address      (addr),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe)
    );

    // Port A captures sX on an OUTPUT addressed to its port id
    always_ff @(posedge clk) begin
        if (rst) begin
            portA_out <= 8'h00;
        end else if (write_strobe && port_id == PORTA_ID) begin
            portA_out <= out_port;
        end
    end

endmodule

// File: tb/tb_bamse_top.sv
// tb/tb_bamse_top.sv - directed scoreboard bench for bamse_top
module tb_bamse_top;

    localparam logic [17:0] NOP = 18'h3F000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq = 1'b0;
    logic [7:0] portA_out;
    logic [7:0] portB_in = 8'hA5;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_count;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    bamse_top dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .portA_out (portA_out),
        .portB_in  (portB_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) wr_count <= 0;
        else if (dut.write_strobe && dut.port_id == 8'h00) wr_count <= wr_count + 1;
    end

    function automatic logic [17:0] ik(input logic [5:0] op, input logic [3:0] x, input logic [7:0] k);
        return {op, x, k};
    endfunction

    function automatic logic [17:0] rr(input logic [5:0] op, input logic [3:0] x, input logic [3:0] y);
        return {op | 6'h01, x, y, 4'h0};
    endfunction

    function automatic logic [17:0] br(input logic [5:0] op, input logic [1:0] cc, input logic [9:0] a);
        return {op, cc, a};
    endfunction

    task automatic expect_val(input string tag, input logic [17:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [17:0] obs);
        logic [17:0] e;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [9:0] a, input logic [17:0] w);
        dut.rom.ram[a] = w;
    endtask

    task automatic begin_test();
        rst = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.rom.ram[i] = NOP;
    endtask

    task automatic release_reset();
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset, output port, input port
        begin_test();
        put(0, ik(6'h00, 0, 8'h5A));
        put(1, ik(6'h2C, 0, 8'h00));
        put(2, ik(6'h00, 0, 8'h33));
        put(3, ik(6'h2C, 0, 8'h01));
        put(4, ik(6'h04, 5, 8'h00));
        put(5, br(6'h34, 2'b00, 10'h005));
        ticks(2);
        expect_val("reset_porta", 18'h00);
        expect_val("reset_addr", 18'h000);
        expect_val("reset_tc", 18'h0);
        expect_val("reset_ie", 18'h0);
        expect_val("reset_sp", 18'h0);
        check(18'(portA_out));
        check(18'(dut.addr));
        check(18'(dut.pblaze.timing_control));
        check(18'(dut.pblaze.ie));
        check(18'(dut.pblaze.sp));
        rst = 1'b0;
        expect_val("tc_after_1", 18'h1);
        expect_val("addr_after_1", 18'h000);
        ticks(1);
        check(18'(dut.pblaze.timing_control));
        check(18'(dut.addr));
        expect_val("tc_after_2", 18'h0);
        expect_val("addr_after_2", 18'h001);
        ticks(1);
        check(18'(dut.pblaze.timing_control));
        check(18'(dut.addr));
        expect_val("porta_before_out", 18'h00);
        ticks(1);
        check(18'(portA_out));
        expect_val("porta_at_4", 18'h5A);
        expect_val("addr_at_4", 18'h002);
        ticks(1);
        check(18'(portA_out));
        check(18'(dut.addr));
        expect_val("porta_port01_ignored", 18'h5A);
        expect_val("s0_reload", 18'h33);
        ticks(4);
        check(18'(portA_out));
        check(18'(dut.pblaze.register.dpr[0]));
        expect_val("input_s5", 18'hA5);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[5]));

        // Arithmetic and flags
        begin_test();
        put(0, ik(6'h00, 1, 8'hFF));
        put(1, ik(6'h18, 1, 8'h01));
        put(2, ik(6'h1C, 1, 8'h01));
        put(3, ik(6'h14, 1, 8'hFF));
        put(4, ik(6'h00, 2, 8'h10));
        put(5, rr(6'h0E, 1, 2));
        put(6, ik(6'h1A, 1, 8'h11));
        put(7, ik(6'h1E, 1, 8'h00));
        put(8, br(6'h34, 2'b00, 10'h008));
        release_reset();
        expect_val("add_s1", 18'h00); expect_val("add_z", 18'h1); expect_val("add_c", 18'h1);
        ticks(4);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.z_flag)); check(18'(dut.pblaze.c_flag));
        expect_val("sub_s1", 18'hFF); expect_val("sub_z", 18'h0); expect_val("sub_c", 18'h1);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.z_flag)); check(18'(dut.pblaze.c_flag));
        expect_val("cmp_s1", 18'hFF); expect_val("cmp_z", 18'h1); expect_val("cmp_c", 18'h0);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.z_flag)); check(18'(dut.pblaze.c_flag));
        expect_val("xor_s1", 18'hEF); expect_val("xor_z", 18'h0);
        ticks(4);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.z_flag));
        expect_val("addcy_s1", 18'h00); expect_val("addcy_c", 18'h1);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.c_flag));
        expect_val("subcy_s1", 18'hFF); expect_val("subcy_c", 18'h1);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[1])); check(18'(dut.pblaze.c_flag));

        // CALL / RETURN / conditional JUMP
        begin_test();
        put(0, ik(6'h00, 0, 8'h77));
        put(1, br(6'h30, 2'b00, 10'h010));
        put(2, br(6'h35, 2'b00, 10'h100));
        put(3, br(6'h34, 2'b00, 10'h003));
        put(10'h010, ik(6'h2C, 0, 8'h00));
        put(10'h011, 18'h2A000);
        release_reset();
        expect_val("call_addr", 18'h010); expect_val("call_sp", 18'h1);
        ticks(4);
        check(18'(dut.addr)); check(18'(dut.pblaze.sp));
        expect_val("ret_addr", 18'h002); expect_val("ret_sp", 18'h0);
        ticks(4);
        check(18'(dut.addr)); check(18'(dut.pblaze.sp));
        expect_val("jz_fallthrough", 18'h003);
        ticks(2);
        check(18'(dut.addr));
        expect_val("call_porta", 18'h77); expect_val("call_writes", 18'h1);
        ticks(6);
        check(18'(portA_out)); check(18'(wr_count));

        // Interrupt taken and returned from
        begin_test();
        put(0, ik(6'h00, 3, 8'h00));
        put(1, 18'h3C001);
        put(2, ik(6'h18, 3, 8'h01));
        put(3, br(6'h34, 2'b00, 10'h002));
        put(10'h3FF, br(6'h34, 2'b00, 10'h3E0));
        put(10'h3E0, ik(6'h00, 4, 8'hFF));
        put(10'h3E1, ik(6'h18, 4, 8'h01));
        put(10'h3E2, ik(6'h2C, 4, 8'h00));
        put(10'h3E3, 18'h38001);
        release_reset();
        expect_val("irq_ie_set", 18'h1);
        ticks(100);
        check(18'(dut.pblaze.ie));
        irq = 1'b1;
        expect_val("irq_pending", 18'h1);
        ticks(1);
        check(18'(dut.pblaze.pending));
        irq = 1'b0;
        expect_val("irq_vector", 18'h3FF); expect_val("irq_ie_clr", 18'h0);
        expect_val("irq_pending_clr", 18'h0); expect_val("irq_sp", 18'h1);
        ticks(1);
        check(18'(dut.addr)); check(18'(dut.pblaze.ie));
        check(18'(dut.pblaze.pending)); check(18'(dut.pblaze.sp));
        expect_val("isr_z", 18'h1); expect_val("isr_c", 18'h1);
        ticks(6);
        check(18'(dut.pblaze.z_flag)); check(18'(dut.pblaze.c_flag));
        expect_val("reti_addr", 18'h002); expect_val("reti_z", 18'h0); expect_val("reti_c", 18'h0);
        expect_val("reti_ie", 18'h1); expect_val("reti_s3", 18'h18);
        ticks(4);
        check(18'(dut.addr)); check(18'(dut.pblaze.z_flag)); check(18'(dut.pblaze.c_flag));
        check(18'(dut.pblaze.ie)); check(18'(dut.pblaze.register.dpr[3]));
        expect_val("resume_s3", 18'h19);
        ticks(2);
        check(18'(dut.pblaze.register.dpr[3]));

        // Same pulse with interrupts disabled
        begin_test();
        put(0, ik(6'h00, 3, 8'h00));
        put(1, 18'h3C000);
        put(2, ik(6'h18, 3, 8'h01));
        put(3, br(6'h34, 2'b00, 10'h002));
        release_reset();
        ticks(100);
        irq = 1'b1;
        expect_val("dis_pending", 18'h0);
        ticks(1);
        check(18'(dut.pblaze.pending));
        irq = 1'b0;
        expect_val("dis_addr", 18'h003);
        ticks(1);
        check(18'(dut.addr));
        expect_val("dis_addr_late", 18'h002); expect_val("dis_s3", 18'h1B);
        ticks(10);
        check(18'(dut.addr)); check(18'(dut.pblaze.register.dpr[3]));

        // PC wrap through 0x3FF
        begin_test();
        put(0, br(6'h34, 2'b00, 10'h3FC));
        release_reset();
        expect_val("wrap_jump", 18'h3FC);
        ticks(2);
        check(18'(dut.addr));
        expect_val("wrap_zero", 18'h000);
        ticks(8);
        check(18'(dut.addr));

        // Stack pointer wraps modulo 31
        begin_test();
        put(0, br(6'h30, 2'b00, 10'h000));
        release_reset();
        expect_val("sp_30", 18'd30);
        ticks(60);
        check(18'(dut.pblaze.sp));
        expect_val("sp_wrap0", 18'd0);
        ticks(2);
        check(18'(dut.pblaze.sp));
        expect_val("sp_wrap1", 18'd1);
        ticks(2);
        check(18'(dut.pblaze.sp));

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
